// File: rtl/inst_loader_pkg.sv
// Shared definitions for the UART instruction loader.
//   - RX receiver state encodings (IDLE, START, DATA, STOP)
//   - 8N1 frame constants
//   - instruction-memory address width
package inst_loader_pkg;

  // Receiver FSM states, kept as plain constants for legacy tool flows.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // 8N1 framing.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Instruction word geometry.
  localparam int ADDR_W     = 10;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/inst_loader_uart_rx.sv
// 8N1 UART receiver.
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rxd       serial input, idle high, LSB first
//   rx_data   received byte, valid while rx_valid=1
//   rx_valid  one-cycle strobe: byte received with a good stop bit
//   rx_ferr   one-cycle strobe: stop bit sampled low, byte dropped
//   active    high whenever the FSM is outside IDLE
module uart_rx
  import inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  logic             sync1, sync2, rx_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;

  // Sync flops and edge history reset to the idle level so the first
  // falling edge after reset is seen as a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // which is what turns this chain into a real two-stage synchronizer.
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !sync2) state <= RX_START;
        end
        // Wait half a bit and confirm the line is still low; a short low
        // pulse is treated as noise.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // From mid-start, every full bit period lands mid-bit.
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shift_q <= {sync2, shift_q[7:1]};
            if (bit_idx == BIT_LAST) state <= RX_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            rx_valid <= sync2;
            rx_ferr  <= !sync2;
            state    <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data = shift_q;
  assign active  = (state != RX_IDLE);

endmodule

// File: rtl/inst_loader.sv
// Loads 32-bit instructions received over UART into an instruction memory.
// Four bytes per word, big-endian, written to consecutive word addresses.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rxd        UART serial in (8N1)
//   load_en    loader enable; a falling edge drops any partial word
//   we         one-cycle write strobe
//   waddr      word address, valid with we
//   wdata      assembled instruction, holds between writes
//   busy       frame in progress or partial word held
//   done       DEPTH words written; later bytes ignored
//   frame_err  sticky bad-stop-bit flag
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        load_en,
  output logic        we,
  output logic [9:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr, rx_active;
  logic              load_en_q;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] addr;
  logic              accept;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .active   (rx_active)
  );

  assign accept = rx_valid && load_en && !done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_en_q <= 1'b0;
      byte_idx  <= '0;
      asm_q     <= '0;
      addr      <= '0;
      we        <= 1'b0;
      wdata     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      we        <= 1'b0;
      load_en_q <= load_en;

      // The last address is held so waddr never wraps back to 0.
      if (we && addr != LAST_ADDR) addr <= addr + 1'b1;

      if (rx_ferr) begin
        frame_err <= 1'b1;
        byte_idx  <= '0;
      end else if (load_en_q && !load_en) begin
        byte_idx <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          2'd0: asm_q[23:16] <= rx_data;
          2'd1: asm_q[15:8]  <= rx_data;
          2'd2: asm_q[7:0]   <= rx_data;
          default: begin
            we    <= 1'b1;
            wdata <= {asm_q, rx_data};
            if (addr == LAST_ADDR) done <= 1'b1;
          end
        endcase
      end
    end
  end

  assign waddr = addr;
  assign busy  = rx_active || (byte_idx != 2'd0);

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (CLKS_PER_BIT=4, DEPTH=4).
module tb_inst_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic        load_en = 1'b1;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        busy, done, frame_err;

  int vectors = 0;
  int errors  = 0;

  // Write log filled by the monitor.
  int          we_count = 0;
  logic [9:0]  log_addr [64];
  logic [31:0] log_data [64];
  int          we_back2back = 0;
  logic        we_prev = 1'b0;

  inst_loader #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .load_en   (load_en),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      if (we_count < 64) begin
        log_addr[we_count] = waddr;
        log_data[we_count] = wdata;
      end
      we_count = we_count + 1;
      if (we_prev) we_back2back = we_back2back + 1;
    end
    we_prev = we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bit_period(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, stop, then one idle bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop_bit);
    bit_period(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " we"},        32'(we),        32'd0);
    check({pfx, " waddr"},     32'(waddr),     32'd0);
    check({pfx, " wdata"},     wdata,          32'd0);
    check({pfx, " busy"},      32'(busy),      32'd0);
    check({pfx, " done"},      32'(done),      32'd0);
    check({pfx, " frame_err"}, 32'(frame_err), 32'd0);
  endtask

  int base;
  logic [31:0] words [4];

  initial begin
    words[0] = 32'h11223344;
    words[1] = 32'h12233445;
    words[2] = 32'h13243546;
    words[3] = 32'h14253647;

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single word.
    base = we_count;
    send_word(32'h20080005);
    check("w1 we_count", 32'(we_count - base), 32'd1);
    check("w1 waddr",    32'(log_addr[base]),  32'd0);
    check("w1 wdata",    log_data[base],       32'h20080005);
    check("w1 busy",     32'(busy),            32'd0);
    check("w1 addr_inc", 32'(waddr),           32'd1);
    check("w1 hold",     wdata,                32'h20080005);

    // One-clock glitch.
    do_reset();
    base = we_count;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("gl busy",      32'(busy),           32'd0);
    check("gl frame_err", 32'(frame_err),      32'd0);
    check("gl no_we",     32'(we_count - base), 32'd0);

    // Bad stop bit followed by a good word.
    do_reset();
    base = we_count;
    send_byte(8'hAA, 1'b0);
    repeat (2) @(negedge clk);
    check("fe frame_err", 32'(frame_err), 32'd1);
    check("fe busy",      32'(busy),      32'd0);
    send_word(32'h12345678);
    check("fe we_count",  32'(we_count - base), 32'd1);
    check("fe waddr",     32'(log_addr[base]),  32'd0);
    check("fe wdata",     log_data[base],       32'h12345678);
    check("fe sticky",    32'(frame_err),       32'd1);

    // Reset mid-DATA of the third byte (frame_err and wdata are nonzero here).
    send_byte(8'h11);
    send_byte(8'h22);
    bit_period(1'b0);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("mr busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mr");
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    base = we_count;
    send_word(32'h01020304);
    check("mr we_count", 32'(we_count - base), 32'd1);
    check("mr waddr",    32'(log_addr[base]),  32'd0);
    check("mr wdata",    log_data[base],       32'h01020304);

    // load_en falling edge drops a partial word.
    do_reset();
    base = we_count;
    send_byte(8'h55);
    send_byte(8'h66);
    check("le busy_part", 32'(busy), 32'd1);
    load_en = 1'b0;
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    check("le busy_drop", 32'(busy), 32'd0);
    send_word(32'hDEADBEEF);
    check("le we_count", 32'(we_count - base), 32'd1);
    check("le waddr",    32'(log_addr[base]),  32'd0);
    check("le wdata",    log_data[base],       32'hDEADBEEF);

    // Fill DEPTH=4 words, then confirm later bytes are ignored.
    do_reset();
    base = we_count;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("fill done_early", 32'(done), 32'd0);
      send_word(words[i]);
    end
    check("fill we_count", 32'(we_count - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill waddr%0d", i), 32'(log_addr[base + i]), 32'(i));
      check($sformatf("fill wdata%0d", i), log_data[base + i], words[i]);
    end
    check("fill done", 32'(done), 32'd1);
    check("fill waddr_hold", 32'(waddr), 32'd3);
    send_word(32'hFFEEDDCC);
    check("post we_count", 32'(we_count - base), 32'd4);
    check("post done",     32'(done),  32'd1);
    check("post waddr",    32'(waddr), 32'd3);
    check("post wdata",    wdata,      words[3]);
    check("we back2back",  32'(we_back2back), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, system clocks per UART bit (100 MHz / 115200); legal minimum 4.
REQ-002 Parameter: DEPTH, default 1024, instruction words in the target memory.
REQ-003 Port: clk  input  1  system clock; all logic rising-edge.
REQ-004 Port: rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port: rxd  input  1  UART serial in, 8N1, LSB first, idle high.
REQ-006 Port: load_en  input  1  loader enable; while low, the loader discards received bytes and holds the address.
REQ-007 Port: we  output  1  instruction-memory write strobe, one-cycle pulse.
REQ-008 Port: waddr  output  10  word address of the write; valid while we=1.
REQ-009 Port: wdata  output  32  32-bit instruction; valid while we=1.
REQ-010 Port: busy  output  1  high while a UART frame is in progress or a word is partially assembled.
REQ-011 Port: done  output  1  high once DEPTH words have been written.
REQ-012 Port: frame_err  output  1  sticky; set on a bad stop bit.

Function
REQ-013 rxd shall pass through a 2-flop synchronizer reset to 1 before any use.
REQ-014 The receiver FSM shall have states IDLE, START, DATA and STOP.
REQ-015 IDLE->START on a synchronized falling edge; START waits CLKS_PER_BIT/2 clocks and resamples: 0 -> DATA, 1 -> IDLE (glitch rejected, no byte).
REQ-016 DATA samples 8 bits at CLKS_PER_BIT intervals from mid-start, LSB first, then goes to STOP.
REQ-017 STOP samples at mid-stop-bit: 1 -> byte valid, one-cycle internal strobe; 0 -> frame_err set, byte discarded, byte index cleared to 0; either way -> IDLE.
REQ-018 Valid bytes shall assemble big-endian: the first byte goes to wdata[31:24] and the fourth to wdata[7:0]; the 2-bit byte index wraps 3->0.
REQ-019 we shall pulse exactly one clock after the fourth byte's valid strobe, with waddr = current word address and wdata = assembled word.
REQ-020 The word address shall increment by 1 on the clock after we; the address after DEPTH-1 shall not wrap: done sets with we of word DEPTH-1, and all later bytes are ignored.
REQ-021 Bytes completing while load_en=0 or done=1 shall be discarded without changing byte index, address, wdata or we.
REQ-022 A falling edge of load_en shall clear the byte index (partial word dropped) but keep the address.
REQ-023 busy = (FSM != IDLE) or (byte index != 0).
REQ-024 wdata shall hold its last value between writes; we shall never be high for two consecutive clocks.

Reset
REQ-025 On rst=0, at any time including mid-frame, all state shall clear asynchronously: FSM=IDLE, synchronizer=1, byte index=0, address=0.
REQ-026 Output values while rst=0: we=0, waddr=0, wdata=0, busy=0, done=0, frame_err=0.
REQ-027 After rst rises, the first falling edge of rxd shall be treated as a new start bit.

Structure
REQ-028 A shared package shall hold the RX state enumeration, the 8N1 frame constants (DATA_BITS=8) and ADDR_W=10.
REQ-029 The UART receiver (REQ-013 to REQ-017) shall be a sub-module uart_rx with outputs rx_data[7:0], rx_valid and rx_ferr.
REQ-030 Word assembly, addressing and done logic shall reside in inst_loader.

Verification (CLKS_PER_BIT=4, DEPTH=4 unless noted)
REQ-031 Send bytes 0x20,0x08,0x00,0x05 with load_en=1 -> single we pulse, waddr=0, wdata=0x20080005, then busy=0.
REQ-032 Send 16 bytes encoding 4 words, then 4 more -> we at waddr 0..3, done=1 after the 4th word, no further we.
REQ-033 Send a 1-clock low glitch on rxd -> no byte, busy returns to 0, frame_err=0.
REQ-034 Send 0xAA with stop bit=0, then 0x12,0x34,0x56,0x78 -> frame_err=1, one we with wdata=0x12345678 at waddr=0.
REQ-035 Assert rst=0 mid-DATA of the third byte, release, then send 4 bytes 0x01..0x04 -> all outputs 0 during reset; we with waddr=0, wdata=0x01020304.
REQ-036 Send 2 bytes, drop load_en for 1 clock, then send 0xDE,0xAD,0xBE,0xEF -> we with wdata=0xDEADBEEF at waddr=0.
